// File: rtl/dds_dac_frame_ctrl_pkg.sv
// Shared DDS DAC framing definitions.
// State encoding, default sizes and counter-width helper.
package dds_dac_frame_ctrl_pkg;

  localparam int DDS_DATA_W     = 12;
  localparam int DDS_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dds_state_t;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dds_dac_frame_ctrl_shift.sv
// DAC serialiser shift register.
// Parallel load, left shift with zero fill, MSB out.
module dac_shift12 #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_din,
  input  logic         i_shift,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_din;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/dds_dac_frame_ctrl.sv
// DDS sample to serial DAC frame controller.
// One sample per frame, Cs_n framed, MSB first.
module dds_dac_frame_ctrl
  import dds_dac_frame_ctrl_pkg::*;
#(
  parameter int DATA_W     = DDS_DATA_W,
  parameter int GAP_CYCLES = DDS_GAP_CYCLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Samp,
  input  logic              Samp_Valid,
  output logic              Samp_Ready,
  output logic              Sdo,
  output logic              Cs_n,
  output logic              Busy,
  output logic              Frame_Done
);

  localparam int BIT_W = cnt_w(DATA_W);
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam int GAP_L = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_L);

  dds_state_t       r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_cs_n;
  logic             r_done;

  logic w_accept;
  logic w_shift_en;
  logic w_msb;

  assign Samp_Ready = (r_state == ST_IDLE) && !Rst;
  assign w_accept   = Samp_Valid && Samp_Ready;
  assign w_shift_en = (r_state == ST_SHIFT);

  dac_shift12 #(
    .W (DATA_W)
  ) u_shift (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_accept),
    .i_din   (Samp),
    .i_shift (w_shift_en),
    .o_msb   (w_msb)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= '0;
            r_cs_n    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
            r_cs_n    <= 1'b1;
            r_done    <= 1'b1;
            r_gap_cnt <= '0;
            // A zero gap returns straight to the accept cycle.
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
        end
      endcase
    end
  end

  assign Sdo        = w_shift_en & w_msb;
  assign Cs_n       = r_cs_n;
  assign Busy       = (r_state != ST_IDLE);
  assign Frame_Done = r_done;

endmodule
